// File: rtl/pulse_cdc_pkg.sv
// Shared definitions for the source-side req/ack pulse crossing.
package pulse_cdc_pkg;

    // Handshake phase of the request launcher.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Cycles allowed per handshake phase unless overridden.
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding the queued event count.
// Simultaneous inc and dec cancel; an inc at full scale is reported on sat_hit.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // An event is lost only when it arrives alone at full scale.
    assign sat_hit = inc & ~dec & (cnt == CNT_MAX);

    // Count update; never wraps in either direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_req_queue.sv
// Source-domain front end of the four-phase pulse crossing: queues event
// pulses and launches them one req/ack handshake at a time, with sticky
// overflow and per-phase timeout reporting.
module pulse_req_queue
    import pulse_cdc_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             ack_in,
    input  logic             clr_err,
    output logic             req_out,
    output logic             sent,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             timeout_err
);

    // Timer width follows TIMEOUT; kept at least one bit when timeout is off.
    localparam int              TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TO_EN   = (TIMEOUT > 0);

    state_t          state, state_nx;
    logic [TO_W-1:0] timer, timer_nx;
    logic            sent_nx;
    logic            toe_set;
    logic            launch;
    logic            sat_hit;
    logic            to_hit;

    // Launch consumes one queued event whenever the line is idle.
    assign launch = (state == IDLE) && (pending != '0);
    assign to_hit = TO_EN && (timer == TO_LAST);

    sat_updown_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (pulse_in),
        .dec    (launch),
        .cnt    (pending),
        .sat_hit(sat_hit)
    );

    // Next-state, phase timer and sent pulse.
    always_comb begin
        state_nx = state;
        timer_nx = '0;
        sent_nx  = 1'b0;
        toe_set  = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nx = REQ;
            end
            REQ: begin
                if (ack_in) begin
                    state_nx = RELEASE;
                    sent_nx  = 1'b1;
                end else if (to_hit) begin
                    // Stalled request: abandon the event and drop req.
                    state_nx = RELEASE;
                    toe_set  = 1'b1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_in) begin
                    state_nx = IDLE;
                end else if (to_hit) begin
                    // Keep waiting for ack to fall, re-arming the timer.
                    toe_set = 1'b1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, registered outputs and sticky flags (set wins over clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            req_out     <= 1'b0;
            sent        <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            req_out     <= (state_nx == REQ);
            sent        <= sent_nx;
            busy        <= (state_nx != IDLE);
            overflow    <= sat_hit | (overflow & ~clr_err);
            timeout_err <= toe_set | (timeout_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_pulse_req_queue.sv
// Self-checking bench for pulse_req_queue: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pulse_req_queue;

    logic clk = 1'b0;
    logic rst, pulse, clr, ack_man, ack_resp, ack_b;
    logic ack_a;
    bit   resp_on;
    int   resp_lat, resp_cnt;

    logic       req_a, sent_a, busy_a, ovf_a, toe_a;
    logic [3:0] pend_a;
    logic       req_b, sent_b, busy_b, ovf_b, toe_b;
    logic [1:0] pend_b;
    logic [8:0] act_a, act_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign ack_a = resp_on ? ack_resp : ack_man;
    assign act_a = {req_a, sent_a, busy_a, pend_a, ovf_a, toe_a};
    assign act_b = {req_b, sent_b, busy_b, 2'b00, pend_b, ovf_b, toe_b};

    pulse_req_queue dut_a (
        .clk(clk), .reset(rst), .pulse_in(pulse), .ack_in(ack_a), .clr_err(clr),
        .req_out(req_a), .sent(sent_a), .busy(busy_a), .pending(pend_a),
        .overflow(ovf_a), .timeout_err(toe_a)
    );

    pulse_req_queue #(.CNT_W(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(rst), .pulse_in(pulse), .ack_in(ack_b), .clr_err(clr),
        .req_out(req_b), .sent(sent_b), .busy(busy_b), .pending(pend_b),
        .overflow(ovf_b), .timeout_err(toe_b)
    );

    // Remote responder for dut_a: follows req_out after resp_lat cycles.
    initial ack_resp = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!resp_on) begin
            resp_cnt = 0;
            ack_resp = 1'b0;
        end else if (req_a != ack_resp) begin
            resp_cnt++;
            if (resp_cnt >= resp_lat) begin
                ack_resp = req_a;
                resp_cnt = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1 = requesting, 2 = waiting for ack release
    typedef struct {
        int pend; int phase; int timer;
        bit req; bit sent; bit busy; bit ovf; bit toe;
    } m_t;

    m_t ma, mb;

    function automatic m_t mreset();
        m_t m;
        m.pend = 0; m.phase = 0; m.timer = 0;
        m.req = 0; m.sent = 0; m.busy = 0; m.ovf = 0; m.toe = 0;
        return m;
    endfunction

    function automatic m_t step(m_t m, int cmax, int to, bit p, bit a, bit c);
        m_t n = m;
        bit go  = (m.phase == 0) && (m.pend != 0);
        bit lost = 0;
        bit stall = 0;
        n.sent  = 0;
        n.timer = 0;
        if (p && !go) begin
            if (m.pend == cmax) lost = 1; else n.pend = m.pend + 1;
        end else if (!p && go) begin
            n.pend = m.pend - 1;
        end
        if (m.phase == 0) begin
            if (go) n.phase = 1;
        end else if (m.phase == 1) begin
            if (a) begin n.phase = 2; n.sent = 1; end
            else if (to != 0 && m.timer == to - 1) begin n.phase = 2; stall = 1; end
            else n.timer = m.timer + 1;
        end else begin
            if (!a) n.phase = 0;
            else if (to != 0 && m.timer == to - 1) stall = 1;
            else n.timer = m.timer + 1;
        end
        n.req  = (n.phase == 1);
        n.busy = (n.phase != 0);
        n.ovf  = lost  ? 1'b1 : (c ? 1'b0 : m.ovf);
        n.toe  = stall ? 1'b1 : (c ? 1'b0 : m.toe);
        return n;
    endfunction

    function automatic logic [8:0] mvec(m_t m);
        return {m.req, m.sent, m.busy, 4'(m.pend), m.ovf, m.toe};
    endfunction

    // Advance one clock; models see the same pre-edge inputs as the DUTs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = step(ma, 15, 64, pulse, ack_a, clr);
            mb = step(mb, 3, 8, pulse, ack_b, clr);
        end
        #2;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; pulse = 0; clr = 0; ack_man = 0; ack_b = 0; resp_on = 0; resp_lat = 1;
        ma = mreset(); mb = mreset();
        #3;
        checks++;
        if (act_a !== 9'd0) begin fails++; $display("FAIL reset_a act=%h exp=%h", act_a, 9'd0); end
        checks++;
        if (act_b !== 9'd0) begin fails++; $display("FAIL reset_b act=%h exp=%h", act_b, 9'd0); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int ns = 0;
        apply_reset();
        resp_lat = 3; resp_on = 1;
        pulse = 1; tick(); pulse = 0;
        checks++;
        if (pend_a !== 4'd1 || req_a !== 1'b0) begin
            fails++; $display("FAIL single_queued act=pend%0d/req%0b exp=pend1/req0", pend_a, req_a);
        end
        tick();
        checks++;
        if (pend_a !== 4'd0 || req_a !== 1'b1) begin
            fails++; $display("FAIL single_launch act=pend%0d/req%0b exp=pend0/req1", pend_a, req_a);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sent_a) ns++;
            checks++;
            if (act_a !== mvec(ma)) begin fails++; $display("FAIL single_model act=%h exp=%h", act_a, mvec(ma)); end
        end
        checks++;
        if (ns != 1) begin fails++; $display("FAIL single_sent_count act=%0d exp=1", ns); end
        checks++;
        if (busy_a !== 1'b0) begin fails++; $display("FAIL single_idle act=%0b exp=0", busy_a); end
        resp_on = 0;
    endtask

    task automatic test_burst();
        int peak = 0, ns = 0, rises = 0;
        logic prev = 0;
        apply_reset();
        resp_lat = 4; resp_on = 1;
        for (int i = 0; i < 120; i++) begin
            pulse = (i < 5);
            tick();
            if (int'(pend_a) > peak) peak = int'(pend_a);
            if (sent_a) ns++;
            if (req_a && !prev) rises++;
            prev = req_a;
            checks++;
            if (act_a !== mvec(ma)) begin fails++; $display("FAIL burst_model act=%h exp=%h", act_a, mvec(ma)); end
        end
        pulse = 0;
        checks++;
        if (peak != 4) begin fails++; $display("FAIL burst_peak act=%0d exp=4", peak); end
        checks++;
        if (ns != 5) begin fails++; $display("FAIL burst_sent act=%0d exp=5", ns); end
        checks++;
        if (rises != 5) begin fails++; $display("FAIL burst_rises act=%0d exp=5", rises); end
        checks++;
        if (ovf_a !== 1'b0 || busy_a !== 1'b0 || pend_a !== 4'd0) begin
            fails++; $display("FAIL burst_end act=ovf%0b/busy%0b/pend%0d exp=0/0/0", ovf_a, busy_a, pend_a);
        end
        resp_on = 0;
    endtask

    task automatic test_saturate();
        apply_reset();
        ack_b = 0; ack_man = 0;
        for (int i = 0; i < 5; i++) begin pulse = 1; tick(); end
        pulse = 0;
        checks++;
        if (pend_b !== 2'd3 || ovf_b !== 1'b1) begin
            fails++; $display("FAIL sat_hit act=pend%0d/ovf%0b exp=pend3/ovf1", pend_b, ovf_b);
        end
        checks++;
        if (ovf_a !== 1'b0) begin fails++; $display("FAIL sat_wide act=%0b exp=0", ovf_a); end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (ovf_b !== 1'b1) begin fails++; $display("FAIL sat_sticky act=%0b exp=1", ovf_b); end
        clr = 1; tick(); clr = 0;
        checks++;
        if (ovf_b !== 1'b0) begin fails++; $display("FAIL sat_clear act=%0b exp=0", ovf_b); end
    endtask

    task automatic test_timeout();
        int hi = 0, ns = 0;
        bit rose = 0;
        apply_reset();
        ack_b = 0;
        pulse = 1; tick(); tick(); pulse = 0;
        if (req_b) hi = 1;
        for (int i = 0; i < 40 && req_b; i++) begin
            tick();
            if (sent_b) ns++;
            if (req_b) hi++;
        end
        checks++;
        if (hi != 8) begin fails++; $display("FAIL to_req_cycles act=%0d exp=8", hi); end
        checks++;
        if (toe_b !== 1'b1) begin fails++; $display("FAIL to_flag act=%0b exp=1", toe_b); end
        for (int i = 0; i < 10 && !rose; i++) begin
            tick();
            if (sent_b) ns++;
            if (req_b) rose = 1;
        end
        checks++;
        if (!rose || pend_b !== 2'd0) begin
            fails++; $display("FAIL to_relaunch act=rose%0b/pend%0d exp=rose1/pend0", rose, pend_b);
        end
        checks++;
        if (ns != 0) begin fails++; $display("FAIL to_no_sent act=%0d exp=0", ns); end
    endtask

    task automatic test_coincident();
        apply_reset();
        ack_man = 0;
        pulse = 1; tick(); tick(); pulse = 0;
        checks++;
        if (pend_a !== 4'd1 || req_a !== 1'b1) begin
            fails++; $display("FAIL coinc act=pend%0d/req%0b exp=pend1/req1", pend_a, req_a);
        end
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (req_a !== 1'b0 || pend_a !== 4'd0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL async_reset act=req%0b/pend%0d/busy%0b exp=0/0/0", req_a, pend_a, busy_a);
        end
        ma = mreset(); mb = mreset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        ack_man = 0; ack_b = 0;
        for (int i = 0; i < 3000; i++) begin
            pulse = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) ack_man = ~ack_man;
            if ($urandom_range(0, 4) == 0) ack_b = ~ack_b;
            clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (act_a !== mvec(ma)) begin fails++; $display("FAIL rand_a cyc=%0d act=%h exp=%h", i, act_a, mvec(ma)); end
            checks++;
            if (act_b !== mvec(mb)) begin fails++; $display("FAIL rand_b cyc=%0d act=%h exp=%h", i, act_b, mvec(mb)); end
        end
        pulse = 0; clr = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_saturate();
        test_timeout();
        test_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pulse_req_queue.md
Name: pulse_req_queue

Overview:
- Source-domain front end for the four-phase req/ack pulse crossing. It sits directly upstream of the request synchronizer and consumes the synchronized acknowledge coming back.
- Absorbs bursts of single-cycle event pulses into a saturating pending counter. Releases them one at a time as a full req/ack handshake, so no event is dropped while a crossing is in flight.
- Flags overflow and stalled handshakes (timeout) with sticky error bits.

Parameters:
- CNT_W, 4: width of the pending counter; capacity 2**CNT_W-1 events.
- TIMEOUT, 64: cycles allowed in any handshake phase before timeout; 0 disables the timeout.
- TO_W, $clog2(TIMEOUT+1): width of the phase timer; derived, not overridden.

Ports:
- clk  in  1  block clock (source domain).
- reset  in  1  asynchronous, active-high reset.
- pulse_in  in  1  event pulse; each high cycle is one event.
- ack_in  in  1  acknowledge level, already synchronized into clk.
- clr_err  in  1  clears overflow and timeout_err.
- req_out  out  1  request level to the request synchronizer; registered.
- sent  out  1  one-cycle pulse when ack_in is seen high in REQ.
- busy  out  1  high when state != IDLE.
- pending  out  CNT_W  events queued, not yet launched.
- overflow  out  1  sticky; an event was lost at saturation.
- timeout_err  out  1  sticky; a handshake phase exceeded TIMEOUT.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values (immediate, asynchronous): state=IDLE, req_out=0, sent=0, busy=0, pending=0, overflow=0, timeout_err=0, timer=0. A reset mid-handshake drops req_out at once; queued events are discarded.
- States are IDLE, REQ and RELEASE. All outputs are registered.
- IDLE:
  - if pending!=0, go to REQ, set req_out=1, decrement pending (launch); timer=0.
  - pending==0: stay.
- REQ (req_out=1):
  - ack_in=1: go to RELEASE, req_out=0, sent=1 for that one cycle; timer=0.
  - else timer+1.
- RELEASE (req_out=0):
  - ack_in=0: go to IDLE.
  - else timer+1.
- Latency: pulse_in sampled at edge n gives pending=1 after n, req_out=1 after n+1. Back-to-back events re-raise req_out one cycle after returning to IDLE, so there is at least one IDLE cycle between requests.
- Pending counter arithmetic, per cycle: inc=pulse_in, dec=launch.
  - inc&dec: pending unchanged.
  - inc only at 2**CNT_W-1: pending holds and overflow is set.
  - dec is never asserted at 0.
  - Counter never wraps.
- Timeout (only when TIMEOUT!=0):
  - in REQ or RELEASE, when timer reaches TIMEOUT-1 without a transition, set timeout_err and reset timer.
  - REQ timeout: go to RELEASE with req_out=0. The event is lost and sent is not pulsed.
  - RELEASE timeout: stay in RELEASE and re-arm the timer, waiting for ack_in=0.
- clr_err clears both sticky flags next edge. A set condition in the same cycle wins over clr_err.
- ack_in rising while in IDLE (spurious) is ignored; the next launch still goes through REQ.
- pulse_in during any state is counted; it is never blocked by busy.

Decomposition:
- Shared package pulse_cdc_pkg:
  - state enum typedef (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2).
  - helper constant for default TIMEOUT.
- Sub-module sat_updown_counter (params W; ports clk, reset, inc, dec, cnt, sat_hit). It owns the pending arithmetic and saturation.
- FSM, timer and flags stay in pulse_req_queue.

Test Plan:
- Single pulse, ack_in driven 3 cycles after req_out rises and dropped 3 cycles after req_out falls:
  - req_out=1 at cycle 2; sent pulses once.
  - pending goes 1 then 0; busy clears after ack_in falls.
- Burst of 5 consecutive pulse_in cycles with a slow responder (4-cycle ack latency):
  - pending peaks at 4 (one launched immediately).
  - exactly 5 sent pulses, 5 req_out rising edges, no overflow.
- CNT_W=2, 5 pulses while ack_in held 0:
  - pending saturates at 3; overflow=1 and stays 1.
  - clr_err then clears it.
- TIMEOUT=8, ack_in never rises:
  - req_out drops after 8 cycles; timeout_err=1; sent stays 0.
  - next queued event relaunches.
- pulse_in coincident with launch at pending=1: pending stays 1. Assert reset mid-REQ: req_out=0 and pending=0 immediately, without waiting for a clock edge.
